// File: rtl/s_fill_ctrl_pkg.sv
// Shared bcrypt key-schedule definitions: fill FSM encoding, P/S word counts
// and the word-counter to write-address decode helpers.
package s_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    WR_L = 3'd3,
    WR_R = 3'd4
  } state_e;

  localparam int unsigned P_WORDS   = 18;
  localparam int unsigned S_WORDS   = 1024;
  localparam int unsigned LAST_WORD = P_WORDS + S_WORDS - 1;
  localparam int unsigned CNT_W     = 11;
  localparam int unsigned P_ADDR_W  = 5;
  localparam int unsigned S_ADDR_W  = 10;

  // Words 0..P_WORDS-1 land in the P-array, the rest in the S-boxes.
  function automatic logic is_p_word(input logic [CNT_W-1:0] w);
    return (w < CNT_W'(P_WORDS));
  endfunction

  function automatic logic [P_ADDR_W-1:0] p_addr_of(input logic [CNT_W-1:0] w);
    return w[P_ADDR_W-1:0];
  endfunction

  function automatic logic [S_ADDR_W-1:0] s_addr_of(input logic [CNT_W-1:0] w);
    logic [CNT_W-1:0] off;
    off = w - CNT_W'(P_WORDS);
    return off[S_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/s_fill_ctrl.sv
// Blowfish/bcrypt P-array and S-box fill sequencer: requests one encryption per
// word pair and writes the L/R halves to consecutive P then S locations.
module s_fill_ctrl
  import s_fill_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                enc_start,
  input  logic                enc_done,
  input  logic [31:0]         enc_L,
  input  logic [31:0]         enc_R,
  output logic                P_wr_en,
  output logic [P_ADDR_W-1:0] P_wr_addr,
  output logic                S_wr_en,
  output logic [S_ADDR_W-1:0] S_wr_addr,
  output logic [31:0]         wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         l_q, l_d;
  logic [31:0]         r_q, r_d;
  logic                err_q, err_d;
  logic                enc_start_q, enc_start_d;
  logic                p_en_q, p_en_d;
  logic [P_ADDR_W-1:0] p_addr_q, p_addr_d;
  logic                s_en_q, s_en_d;
  logic [S_ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                wr_state_d;

  // Next-state and bookkeeping; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    err_d   = err_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = REQ;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        REQ:  state_d = WAIT;
        WAIT: begin
          if (enc_done) begin
            l_d     = enc_L;
            r_d     = enc_R;
            state_d = WR_L;
          end
        end
        WR_L: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WR_R;
        end
        WR_R: begin
          if (cnt_q == CNT_W'(LAST_WORD)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = REQ;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A completion outside WAIT is a protocol violation unless aborted with it.
    if (enc_done && !abort && (state_q != WAIT)) begin
      err_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so they align with the state
  // they belong to, with address decoded from the word about to be written.
  always_comb begin
    wr_state_d  = (state_d == WR_L) || (state_d == WR_R);
    enc_start_d = (state_d == REQ);
    p_en_d      = wr_state_d && is_p_word(cnt_d);
    s_en_d      = wr_state_d && !is_p_word(cnt_d);
    p_addr_d    = p_en_d ? p_addr_of(cnt_d) : '0;
    s_addr_d    = s_en_d ? s_addr_of(cnt_d) : '0;
    wr_data_d   = wr_data_q;
    if (state_d == WR_L) begin
      wr_data_d = l_d;
    end else if (state_d == WR_R) begin
      wr_data_d = r_d;
    end
    done_d      = (state_d == WR_R) && (cnt_d == CNT_W'(LAST_WORD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      err_q       <= 1'b0;
      enc_start_q <= 1'b0;
      p_en_q      <= 1'b0;
      p_addr_q    <= '0;
      s_en_q      <= 1'b0;
      s_addr_q    <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      err_q       <= err_d;
      enc_start_q <= enc_start_d;
      p_en_q      <= p_en_d;
      p_addr_q    <= p_addr_d;
      s_en_q      <= s_en_d;
      s_addr_q    <= s_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
    end
  end

  assign enc_start = enc_start_q;
  assign P_wr_en   = p_en_q;
  assign P_wr_addr = p_addr_q;
  assign S_wr_en   = s_en_q;
  assign S_wr_addr = s_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_s_fill_ctrl.sv
// Directed/randomized bench for s_fill_ctrl: a random-latency encrypt model
// feeds pairs, and every write is checked against the word-index mapping.
module tb_s_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        enc_start;
  logic        enc_done = 1'b0;
  logic [31:0] enc_L = '0;
  logic [31:0] enc_R = '0;
  logic        P_wr_en;
  logic [4:0]  P_wr_addr;
  logic        S_wr_en;
  logic [9:0]  S_wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  s_fill_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .enc_start (enc_start),
    .enc_done  (enc_done),
    .enc_L     (enc_L),
    .enc_R     (enc_R),
    .P_wr_en   (P_wr_en),
    .P_wr_addr (P_wr_addr),
    .S_wr_en   (S_wr_en),
    .S_wr_addr (S_wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Everything the DUT drives, packed; used for the all-zero checks.
  function automatic logic [63:0] all_outs();
    return {enc_start, P_wr_en, P_wr_addr, S_wr_en, S_wr_addr, wr_data, busy, done, err};
  endfunction

  task automatic idle_check(input string tag, input int n);
    int acts;
    acts = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (P_wr_en || S_wr_en || done || busy || enc_start) acts++;
    end
    chk({tag, " quiet while idle"}, acts, 0);
  endtask

  // One fill. abort_pair: abort (with a coincident enc_done) in WAIT of that
  // pair. glitch_pair: pulse start during WR_L of that pair. rst_pair: pull
  // rst_n low during WR_R of that pair. -1 disables each.
  task automatic fill(input string tag, input int abort_pair, input int glitch_pair,
                      input int rst_pair);
    logic [31:0] lq[$];
    logic [31:0] rq[$];
    int w, pairs, done_cnt, both_hi, bad_wr, lat, cyc, first_bad;
    bit stop, abort_pend, do_abort, do_reset, is_p;
    logic [31:0] exp_data;
    logic [9:0]  obs_addr;
    w = 0; pairs = 0; done_cnt = 0; both_hi = 0; bad_wr = 0; lat = 0; cyc = 0;
    first_bad = -1; stop = 0; abort_pend = 0; do_abort = 0; do_reset = 0;

    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " enc_start one cycle after start"}, enc_start, 1'b1);
    chk({tag, " err cleared by start"}, err, 1'b0);

    while (!stop && cyc < 20000) begin
      cyc++;
      if (P_wr_en && S_wr_en) both_hi++;
      if (P_wr_en || S_wr_en) begin
        is_p     = (w < 18);
        exp_data = (w / 2 < lq.size()) ? ((w % 2 == 0) ? lq[w/2] : rq[w/2]) : 32'hxxxx_xxxx;
        obs_addr = is_p ? 10'(P_wr_addr) : S_wr_addr;
        if ({P_wr_en, S_wr_en} !== (is_p ? 2'b10 : 2'b01) ||
            obs_addr !== (is_p ? 10'(w) : 10'(w - 18)) || wr_data !== exp_data) begin
          bad_wr++;
          if (first_bad < 0) first_bad = w;
        end
        if (w == 0 || w == 17)
          chk($sformatf("%s P write word %0d", tag, w), {P_wr_en, S_wr_en, 5'(P_wr_addr), wr_data},
              {2'b10, 5'(w), exp_data});
        if (w == 18 || w == 19 || w == 1041)
          chk($sformatf("%s S write word %0d", tag, w), {P_wr_en, S_wr_en, S_wr_addr, wr_data},
              {2'b01, 10'(w - 18), exp_data});
        if (w == 2 * glitch_pair) start = 1'b1;
        else start = 1'b0;
        if (w == 2 * rst_pair + 1) do_reset = 1;
        w++;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        chk({tag, " done with final write"}, w, 1042);
        stop = 1;
      end

      // Drive inputs for the next edge.
      enc_done = 1'b0;
      abort    = 1'b0;
      if (do_reset) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " async reset clears outputs"}, all_outs(), 64'd0);
        step();
        chk({tag, " outputs held in reset"}, all_outs(), 64'd0);
        rst_n = 1'b1;
        stop = 1;
      end else if (abort_pend) begin
        abort      = 1'b1;
        enc_done   = 1'b1;
        abort_pend = 0;
        do_abort   = 1;
      end else if (do_abort) begin
        chk({tag, " idle after abort"}, {busy, enc_start, P_wr_en, S_wr_en, done}, 5'b0);
        stop = 1;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          enc_done = 1'b1;
          enc_L    = $urandom;
          enc_R    = $urandom;
          lq.push_back(enc_L);
          rq.push_back(enc_R);
        end
      end
      if (enc_start && !do_reset) begin
        if (pairs == abort_pair) abort_pend = 1;
        else lat = int'($urandom_range(1, 4));
        pairs++;
      end
      if (!stop) step();
    end
    start    = 1'b0;
    enc_done = 1'b0;
    abort    = 1'b0;

    chk({tag, " finished within budget"}, (cyc < 20000), 1'b1);
    chk({tag, " P and S never both high"}, both_hi, 0);
    chk({tag, " mismatching writes"}, bad_wr, 0);
    if (first_bad >= 0) $display("%s first bad write at word %0d", tag, first_bad);
    if (abort_pair >= 0) begin
      chk({tag, " writes before abort"}, w, 2 * abort_pair);
      chk({tag, " requests before abort"}, pairs, abort_pair + 1);
      chk({tag, " no done on abort"}, done_cnt, 0);
    end else if (rst_pair >= 0) begin
      chk({tag, " writes before reset"}, w, 2 * rst_pair + 2);
      chk({tag, " no done on reset"}, done_cnt, 0);
    end else begin
      chk({tag, " total writes"}, w, 1042);
      chk({tag, " total requests"}, pairs, 521);
      chk({tag, " done count"}, done_cnt, 1);
    end
    chk({tag, " err clear after fill"}, err, 1'b0);
    idle_check(tag, 8);
    $display("%s: %0d writes, %0d requests, %0d done, %0d cycles", tag, w, pairs, done_cnt, cyc);
  endtask

  initial begin
    #1;
    chk("reset outputs zero", all_outs(), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle after reset release", all_outs(), 64'd0);

    fill("full fill", -1, -1, -1);
    fill("abort at pair 100", 100, -1, -1);
    fill("refill after abort", -1, -1, -1);

    // Stray completion in IDLE flags err without writing.
    enc_done = 1'b1;
    enc_L    = 32'hdead_beef;
    step();
    enc_done = 1'b0;
    chk("spurious enc_done sets err", {err, busy, P_wr_en, S_wr_en}, 4'b1000);
    step();
    chk("err is sticky", err, 1'b1);

    // abort and start together in IDLE stays idle and keeps err.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort wins over start", {busy, enc_start, err}, 3'b001);

    fill("fill with start glitch in WR_L", -1, 5, -1);
    fill("reset during WR_R", -1, -1, 50);
    fill("fill after reset", -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
